alu_exec: RTL and testbench

ALU_EXEC -- requirements
Module: alu_exec

---
 rtl/alu_exec.sv | 132 +++++++++++++
 tb/tb_alu_exec.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/alu_exec.sv
// Multi-cycle ALU: single-cycle add/and/xor, radix-4 shift-add multiply taking OP_WIDTH/2 busy cycles.
// Synchronous active-low reset; ready drops while a multiply is in flight and requests are then ignored.
module alu_exec #(
  parameter int OP_WIDTH     = 8,
  parameter int RESULT_WIDTH = 2 * OP_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid,
  input  logic [2:0]              op,
  input  logic [OP_WIDTH-1:0]     a,
  input  logic [OP_WIDTH-1:0]     b,
  output logic                    ready,
  output logic                    done,
  output logic [RESULT_WIDTH-1:0] result
);

  localparam int STEPS = OP_WIDTH / 2;
  localparam int CW    = $clog2(STEPS) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_RST = 3'b111;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t                  state_q, state_d;
  logic                    ready_q, ready_d;
  logic                    done_q, done_d;
  logic [RESULT_WIDTH-1:0] result_q, result_d;
  logic [RESULT_WIDTH-1:0] acc_q, acc_d;
  logic [RESULT_WIDTH-1:0] mcand_q, mcand_d;
  logic [OP_WIDTH-1:0]     mplier_q, mplier_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [RESULT_WIDTH-1:0] partial;

  // Two multiplier bits per step: partial is mcand * mplier[1:0].
  always_comb begin
    partial = '0;
    if (mplier_q[0]) partial = mcand_q;
    if (mplier_q[1]) partial = partial + (mcand_q << 1);
  end

  always_comb begin
    state_d  = state_q;
    ready_d  = ready_q;
    done_d   = 1'b0;
    result_d = result_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (valid && ready_q) begin
          case (op)
            OP_ADD: begin
              result_d = RESULT_WIDTH'(a) + RESULT_WIDTH'(b);
              done_d   = 1'b1;
            end
            OP_AND: begin
              result_d = RESULT_WIDTH'(a & b);
              done_d   = 1'b1;
            end
            OP_XOR: begin
              result_d = RESULT_WIDTH'(a ^ b);
              done_d   = 1'b1;
            end
            OP_MUL: begin
              mcand_d  = RESULT_WIDTH'(a);
              mplier_d = b;
              acc_d    = '0;
              cnt_d    = '0;
              state_d  = S_MUL;
              ready_d  = 1'b0;
            end
            OP_RST:  result_d = '0;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        acc_d    = acc_q + partial;
        mcand_d  = mcand_q << 2;
        mplier_d = mplier_q >> 2;
        cnt_d    = cnt_q + CW'(1);
        // Result is only written once the full product is known.
        if (cnt_q == LAST_STEP) begin
          result_d = acc_q + partial;
          done_d   = 1'b1;
          state_d  = S_IDLE;
          ready_d  = 1'b1;
          cnt_d    = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      result_q <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      result_q <= result_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ready  = ready_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_alu_exec.sv
// Bench for alu_exec (OP_WIDTH=8): directed scenarios then random traffic,
// all compared against a cycle-level behavioural model of the request/response rules.
module tb_alu_exec;

  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid;
  logic [2:0]    op;
  logic [W-1:0]  a, b;
  logic          ready, done;
  logic [2*W-1:0] result;

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  bit          m_ready;
  bit          m_done;
  logic [15:0] m_res;
  logic [15:0] m_pend;
  int          m_busy;

  alu_exec #(.OP_WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .valid  (valid),
    .op     (op),
    .a      (a),
    .b      (b),
    .ready  (ready),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: one call per rising edge.
  task automatic model_edge(input bit r, input bit v, input logic [2:0] o,
                            input logic [7:0] x, input logic [7:0] y);
    if (!r) begin
      m_busy = 0; m_ready = 1; m_done = 0; m_res = 16'h0;
    end else if (m_busy > 0) begin
      m_busy--;
      m_done = 0;
      if (m_busy == 0) begin
        m_res   = m_pend;
        m_done  = 1;
        m_ready = 1;
      end
    end else begin
      m_done = 0;
      if (v) begin
        case (o)
          3'd1: begin m_res = 16'(x) + 16'(y); m_done = 1; end
          3'd2: begin m_res = 16'(x & y);      m_done = 1; end
          3'd3: begin m_res = 16'(x ^ y);      m_done = 1; end
          3'd4: begin m_pend = 16'(x) * 16'(y); m_busy = W / 2; m_ready = 0; end
          3'd7: m_res = 16'h0;
          default: ;
        endcase
      end
    end
  endtask

  task automatic tick(input bit r, input bit v, input logic [2:0] o,
                      input logic [7:0] x, input logic [7:0] y);
    rst = r; valid = v; op = o; a = x; b = y;
    @(posedge clk);
    model_edge(r, v, o, x, y);
    @(negedge clk);
    check("ready", 32'(ready), 32'(m_ready));
    check("done", 32'(done), 32'(m_done));
    check("result", 32'(result), 32'(m_res));
  endtask

  initial begin
    m_ready = 1; m_done = 0; m_res = 0; m_pend = 0; m_busy = 0;
    rst = 0; valid = 0; op = 0; a = 0; b = 0;

    // Reset, with valid asserted: nothing may be accepted
    tick(0, 1, 3'd1, 8'h11, 8'h22);
    tick(0, 1, 3'd4, 8'h11, 8'h22);

    // Add with carry, then hold
    tick(1, 1, 3'd1, 8'hFF, 8'h01);
    check("add_carry", 32'(result), 32'h0100);
    tick(1, 0, 3'd0, 8'h00, 8'h00);
    check("add_hold", 32'(result), 32'h0100);

    // Back-to-back and / xor
    tick(1, 1, 3'd2, 8'hF0, 8'h3C);
    check("and", 32'(result), 32'h0030);
    tick(1, 1, 3'd3, 8'hF0, 8'h3C);
    check("xor", 32'(result), 32'h00CC);

    // Max multiply with valid held high while busy
    tick(1, 1, 3'd4, 8'hFF, 8'hFF);
    for (int i = 0; i < 3; i++) tick(1, 1, 3'd1, 8'h01, 8'h01);
    tick(1, 1, 3'd1, 8'h01, 8'h01);
    check("mul_max", 32'(result), 32'hFE01);
    check("mul_done", 32'(done), 32'd1);
    // Request in the cycle done returns is accepted
    tick(1, 1, 3'd1, 8'hFF, 8'hFF);
    check("add_max", 32'(result), 32'h01FE);

    // no_op, reserved, rst_op
    tick(1, 1, 3'd1, 8'h02, 8'h03);
    tick(1, 1, 3'd0, 8'h55, 8'h66);
    check("noop_hold", 32'(result), 32'h0005);
    tick(1, 1, 3'd6, 8'h55, 8'h66);
    check("rsvd_hold", 32'(result), 32'h0005);
    tick(1, 1, 3'd7, 8'h55, 8'h66);
    check("rst_op", 32'(result), 32'h0000);

    // Reset aborts a multiply
    tick(1, 1, 3'd4, 8'h12, 8'h34);
    tick(1, 0, 3'd0, 8'h00, 8'h00);
    tick(0, 1, 3'd1, 8'h09, 8'h09);
    check("abort_ready", 32'(ready), 32'd1);
    tick(1, 1, 3'd1, 8'h01, 8'h02);
    check("post_rst_add", 32'(result), 32'h0003);
    tick(1, 0, 3'd0, 8'h00, 8'h00);
    tick(1, 0, 3'd0, 8'h00, 8'h00);
    tick(1, 0, 3'd0, 8'h00, 8'h00);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      bit          r, v;
      logic [2:0]  o;
      logic [7:0]  x, y;
      r = ($urandom_range(0, 99) != 0);
      v = ($urandom_range(0, 3) != 0);
      o = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) o = 3'd4;
      x = 8'($urandom);
      y = 8'($urandom);
      if ($urandom_range(0, 7) == 0) x = 8'hFF;
      if ($urandom_range(0, 7) == 0) y = 8'hFF;
      tick(r, v, o, x, y);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
